// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   fetch_state_e        - fetch FSM state encoding
//   NOP_INSTR            - RV32I canonical NOP (addi x0, x0, 0), the value
//                          presented to decode while nothing has been fetched
//   DEFAULT_RESET_VECTOR - default PC loaded on reset
// Build option: FETCH_MISALIGN_TRAP_EN adds the sticky FAULT state.
// ----------------------------------------------------------------------------
package fetch_pkg;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_STALL,
    ST_FAULT
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_STALL
  } fetch_state_e;
`endif

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches one instruction at a time: request at pc, wait for the response,
// hold the word for decode until accepted, then stall until the branch stage
// supplies the next pc. One request outstanding at most; every output comes
// straight from a flop.
//
// Parameters:
//   RESET_VECTOR   - PC loaded on reset
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   next_pc        - next PC from the branch control stage
//   pc_update      - one-cycle strobe: load next_pc (honoured only in STALL)
//   imem_req_valid - fetch request (out), imem_req_ready - accepted (in)
//   imem_addr      - fetch address (out)
//   imem_rsp_valid - read data valid (in), imem_rsp_data - instruction word
//   instr_valid    - instr/instr_pc valid for decode (out)
//   instr_ready    - decode accepts the instruction (in)
//   instr, instr_pc- fetched word and its PC (out)
//   fetch_fault    - sticky misaligned-PC flag (only with the macro below)
//
// Build option: `define FETCH_MISALIGN_TRAP_EN to trap a misaligned next_pc
// into a FAULT state left only by reset; otherwise next_pc is word-aligned
// by clearing its two low bits.
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_update,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  aligned_pc;

  // Masking (rather than slicing) keeps every next_pc bit in use in both builds.
  assign aligned_pc = next_pc & ~32'h0000_0003;

  // The pc register is the fetch address, so imem_addr is registered and
  // cannot move while a request waits for ready.
  assign imem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_REQ;
      pc             <= RESET_VECTOR;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= RESET_VECTOR;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault    <= 1'b0;
`endif
    end else begin
      case (state)
        // Request is raised one cycle after entry from reset; the handshake
        // uses the registered valid so ready alone never counts as a transfer.
        ST_REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= ST_WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end

        // pc_update is deliberately not looked at here, even alongside the
        // decode handshake.
        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= ST_STALL;
          end
        end

        ST_STALL: begin
          if (pc_update) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= ST_FAULT;
            end else begin
              pc             <= aligned_pc;
              imem_req_valid <= 1'b1;
              state          <= ST_REQ;
            end
`else
            pc             <= aligned_pc;
            imem_req_valid <= 1'b1;
            state          <= ST_REQ;
`endif
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Sticky: no requests, nothing to decode, only reset leaves.
        ST_FAULT: begin
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
`endif

        default: state <= ST_REQ;
      endcase
    end
  end

endmodule : instruction_fetch_unit
